// File: rtl/write_back.sv
// Write-back stage register: captures the data-memory result and presents it
// one clock later. Synchronous active-low reset clears the register.
module write_back #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ans_dm,
  output logic [WIDTH-1:0] ans_wb
);

  logic [WIDTH-1:0] ans_wb_d;
  logic [WIDTH-1:0] ans_wb_q;

  // Reset wins over the incoming value, so an in-flight result is dropped.
  always_comb begin
    ans_wb_d = ans_dm;
    if (!reset) begin
      ans_wb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    ans_wb_q <= ans_wb_d;
  end

  assign ans_wb = ans_wb_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios followed by random
// stimulus compared against a one-cycle-delay reference model.
module tb_write_back;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] ans_dm;
  logic [WIDTH-1:0] ans_wb;

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference: what the write-back register should hold after the last edge.
  logic [WIDTH-1:0] model_wb;

  write_back #(
    .WIDTH(WIDTH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .ans_dm(ans_dm),
    .ans_wb(ans_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, then check the result just after
  // the rising edge. The output is also checked for stability before driving.
  task automatic step(input string tag, input logic r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    check_eq({tag, "_hold"}, ans_wb, model_wb);
    reset  = r;
    ans_dm = d;
    @(posedge clk);
    model_wb = r ? d : '0;
    #1;
    check_eq(tag, ans_wb, model_wb);
  endtask

  initial begin
    logic [WIDTH-1:0] stream [4];
    logic [WIDTH-1:0] bnd [3];
    logic             r;
    logic [WIDTH-1:0] d;

    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ans_dm   = '0;
    model_wb = '0;

    // Reset pulse spanning the first edge at 5 ns.
    #2 reset = 1'b0;
    #6 reset = 1'b1;
    #2;
    check_eq("reset_pulse", ans_wb, '0);

    stream[0] = 16'd8;
    stream[1] = 16'd42158;
    stream[2] = 16'd7777;
    stream[3] = 16'd1000;
    for (int i = 0; i < 4; i++) step("stream", 1'b1, stream[i]);

    bnd[0] = 16'hFFFF;
    bnd[1] = 16'h0000;
    bnd[2] = 16'h8000;
    for (int i = 0; i < 3; i++) step("boundary", 1'b1, bnd[i]);

    // Repeated value still loads; mid-stream reset drops it.
    step("repeat", 1'b1, 16'h8000);
    step("mid_reset", 1'b0, 16'd1234);
    step("held_reset", 1'b0, 16'd4321);
    step("release", 1'b1, 16'd1234);

    // Glitch on ans_dm between edges must not reach ans_wb.
    step("glitch_pre", 1'b1, 16'd5);
    #1 ans_dm = 16'd9;
    #2;
    check_eq("glitch_mid", ans_wb, 16'd5);
    @(negedge clk);
    ans_dm = 16'd9;
    #2 ans_dm = 16'd5;
    @(posedge clk);
    #1;
    check_eq("glitch_edge", ans_wb, 16'd5);
    model_wb = 16'd5;

    // Short reset pulse strictly between edges has no effect.
    step("pulse_pre", 1'b1, 16'hA5A5);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("async_pulse", ans_wb, 16'hA5A5);
    step("pulse_post", 1'b1, 16'h5A5A);

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(7) != 0);
      d = WIDTH'($urandom);
      step("random", r, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 SHALL declare parameter: WIDTH, default 16, data width of the write-back path in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
REQ-004 SHALL have port: ans_dm  input  WIDTH  result arriving from the data-memory stage.
REQ-005 SHALL have port: ans_wb  output  WIDTH  registered write-back result.
REQ-006 SHALL use exactly one clock domain (clk) and reset (reset), with reset synchronous and active-low; no other clocks, resets or ports.

Function
REQ-007 SHALL implement ans_wb as a WIDTH-bit register driven directly by a flip-flop output, with no combinational path from ans_dm to ans_wb.
REQ-008 SHALL, on each rising clk edge with reset=1, load ans_wb <= ans_dm as sampled at that edge.
REQ-009 SHALL provide a latency of exactly one clock: a value on ans_dm before edge N appears on ans_wb after edge N and holds until edge N+1.
REQ-010 SHALL transfer data bit-exactly, with no sign extension, truncation, arithmetic or reordering; the full unsigned range 0..2^WIDTH-1 passes unchanged.
REQ-011 SHALL update ans_wb on every enabled edge, including when the new value equals the old one; there is no stall, enable or handshake.
REQ-012 SHALL keep ans_wb stable between rising edges regardless of ans_dm activity.
REQ-013 SHALL leave ans_wb undefined from power-up until the first rising edge that samples reset=0; no initial value is relied upon.
REQ-014 SHALL be synthesizable with no latches and no initial blocks affecting function.

Reset
REQ-015 SHALL clear ans_wb to 0 on any rising clk edge at which reset=0, regardless of ans_dm.
REQ-016 SHALL take no action on reset transitions between clock edges: assertion or deassertion affects ans_wb only at the next rising edge (synchronous).
REQ-017 SHALL hold ans_wb at 0 for every edge at which reset remains 0.
REQ-018 SHALL load ans_dm at the first rising edge with reset=1 after deassertion, with no extra recovery cycle.
REQ-019 SHALL, if reset is asserted mid-stream, clear ans_wb at that edge and drop the in-flight value; the value sampled at the first edge after release follows REQ-008.

Verification
REQ-020 SHALL pass reset pulse: clk period 10 ns with the first rising edge at 5 ns; reset 1->0 at 2 ns and 0->1 at 8 ns; ans_dm=0 -> ans_wb=0 after the 5 ns edge.
REQ-021 SHALL pass stream: ans_dm=8, 42158, 7777, 1000 applied at 10, 20, 30 and 40 ns -> ans_wb=8, 42158, 7777, 1000 after the 15, 25, 35 and 45 ns edges respectively, each held for 10 ns.
REQ-022 SHALL pass boundary data: ans_dm=16'hFFFF, then 16'h0000, then 16'h8000 on consecutive cycles -> ans_wb shows the identical values one cycle later, with no sign effects.
REQ-023 SHALL pass mid-stream reset: ans_dm=1234 with reset=0 for one edge -> ans_wb=0 at that edge; reset=1 at the next edge -> ans_wb=1234.
REQ-024 SHALL pass mid-cycle glitch: ans_dm toggles 5->9->5 between two edges -> ans_wb changes only at the edges and shows the value present at each edge.
REQ-025 SHALL pass asynchronous-reset check: reset pulsed low for 2 ns strictly between edges -> ans_wb unchanged.
